uart_bus_controller: RTL and testbench

Parametrised CPU-side controller for the CPLD UART on the shared base-RAM data bus. It drives the rdn/wrn strobes with configurable pulse widths and optionally waits on the UART's tbre/tsre/dataready handshakes with a timeout. It also serves a status word so software can poll the UART instead of blocking. It sits between the MEM stage, which issues load/store/sel_status and honours stall_req, and the bus mux, which consumes write_bus/bus_data_out.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_wait_timer.sv | 39 +++
 rtl/uart_bus_controller.sv | 184 ++++++++++++++++++
 tb/tb_uart_bus_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the CPLD UART bus controller.
// State encoding, status-word layout and small helpers.
package uart_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_WAIT,
    RD_PULSE,
    RD_RECOVER,
    ST_READ,
    WR_PULSE,
    WR_RECOVER,
    WR_WAIT_TBRE,
    WR_WAIT_TSRE
  } uart_state_t;

  localparam int unsigned UART_ST_TXIDLE = 0;
  localparam int unsigned UART_ST_RXRDY  = 1;
  localparam int unsigned UART_ST_ERR    = 2;

  function automatic word_t uart_status(
    input logic tbre,
    input logic tsre,
    input logic dready,
    input logic err
  );
    word_t w;
    w                 = '0;
    w[UART_ST_TXIDLE] = tbre & tsre;
    w[UART_ST_RXRDY]  = dready;
    w[UART_ST_ERR]    = err;
    return w;
  endfunction

  function automatic int unsigned umax3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/uart_wait_timer.sv
// Cycle counter for strobe widths and handshake timeouts.
// expired marks the N-th cycle since clear; never asserted for N = 0.
module uart_wait_timer #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned LAST = (N == 0) ? 0 : N - 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (N != 0) && (cnt_q == LAST[W-1:0]);

  // Saturates on expiry so a stalled wait cannot wrap into a false fire.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_bus_controller.sv
// CPU-side controller for the CPLD UART on the shared base-RAM bus.
// Drives rdn/wrn strobes, waits on UART handshakes, serves a status word.
module uart_bus_controller
  import uart_pkg::*;
#(
  parameter int unsigned RD_CYCLES   = 3,
  parameter int unsigned WR_CYCLES   = 4,
  parameter bit          WAIT_TX     = 1'b1,
  parameter bit          RX_BLOCKING = 1'b0,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  store,
  input  logic  sel_status,
  input  word_t wdata,
  output word_t rdata,
  output logic  stall_req,
  input  word_t bus_data_in,
  output word_t bus_data_out,
  output logic  write_bus,
  output logic  uart_rdn,
  output logic  uart_wrn,
  input  logic  uart_dataready,
  input  logic  uart_tbre,
  input  logic  uart_tsre
);

  localparam int unsigned MAXN = umax3(RD_CYCLES, WR_CYCLES, TIMEOUT);
  localparam int unsigned CW   = $clog2(MAXN + 1);

  uart_state_t state_q;
  uart_state_t state_d;
  word_t       rdata_q;
  word_t       rdata_d;
  logic        err_q;
  logic        err_d;
  logic        rdn_q;
  logic        rdn_d;
  logic        wrn_q;
  logic        wrn_d;
  logic        wb_q;
  logic        wb_d;

  logic st_chg;
  logic in_wait;
  logic rd_done;
  logic wr_done;
  logic tmo;

  logic unused_bits;
  assign unused_bits = ^{bus_data_in[31:8], wdata[31:8]};

  assign st_chg  = (state_d != state_q);
  assign in_wait = state_q inside {RD_WAIT, WR_WAIT_TBRE, WR_WAIT_TSRE};

  uart_wait_timer #(
    .N(RD_CYCLES),
    .W(CW)
  ) u_rd_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (st_chg),
    .enable (state_q == RD_PULSE),
    .expired(rd_done)
  );

  uart_wait_timer #(
    .N(WR_CYCLES),
    .W(CW)
  ) u_wr_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (st_chg),
    .enable (state_q == WR_PULSE),
    .expired(wr_done)
  );

  uart_wait_timer #(
    .N(TIMEOUT),
    .W(CW)
  ) u_tmo_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (st_chg),
    .enable (in_wait),
    .expired(tmo)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (store && !sel_status) begin
          state_d = WR_PULSE;
        end else if (load && sel_status) begin
          state_d = ST_READ;
          rdata_d = uart_status(uart_tbre, uart_tsre,
                                uart_dataready, err_q);
          err_d   = 1'b0;
        end else if (load) begin
          state_d = RX_BLOCKING ? RD_WAIT : RD_PULSE;
        end
      end
      RD_WAIT: begin
        // A late dataready still beats a same-cycle timeout.
        if (uart_dataready) begin
          state_d = RD_PULSE;
        end else if (tmo) begin
          state_d = RD_RECOVER;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RD_PULSE: begin
        if (rd_done) begin
          state_d = RD_RECOVER;
          rdata_d = {24'b0, bus_data_in[7:0]};
        end
      end
      RD_RECOVER: state_d = IDLE;
      ST_READ:    state_d = IDLE;
      WR_PULSE: begin
        if (wr_done) state_d = WR_RECOVER;
      end
      WR_RECOVER: begin
        state_d = WAIT_TX ? WR_WAIT_TBRE : IDLE;
      end
      WR_WAIT_TBRE: begin
        if (uart_tbre) begin
          state_d = WR_WAIT_TSRE;
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WR_WAIT_TSRE: begin
        if (uart_tsre) begin
          state_d = IDLE;
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state to stay glitch-free.
  always_comb begin
    rdn_d = (state_d != RD_PULSE);
    wrn_d = (state_d != WR_PULSE);
    wb_d  = (state_d == WR_PULSE) || (state_d == WR_RECOVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      wb_q    <= wb_d;
    end
  end

  assign rdata        = rdata_q;
  assign stall_req    = (state_d != IDLE);
  assign bus_data_out = {24'b0, wdata[7:0]};
  assign write_bus    = wb_q;
  assign uart_rdn     = rdn_q;
  assign uart_wrn     = wrn_q;

endmodule

// File: tb/tb_uart_bus_controller.sv
// Directed and randomized bench for uart_bus_controller.
// Four configurations, each with its own stimulus lines.
module tb_uart_bus_controller;
  import uart_pkg::*;

  localparam int NI = 4;
  localparam int RD = 3;
  localparam int WR = 4;
  localparam int NEVER = 100000;

  logic  clk = 1'b0;
  logic  rst;
  logic  ld [NI];
  logic  st [NI];
  logic  sl [NI];
  logic  dr [NI];
  logic  tb [NI];
  logic  ts [NI];
  word_t wd [NI];
  word_t bd [NI];
  word_t rdo [NI];
  word_t bdo [NI];
  logic  stall [NI];
  logic  wb [NI];
  logic  rdn [NI];
  logic  wrn [NI];

  int    n_checks = 0;
  int    n_fail = 0;
  int    op_id = 0;
  word_t m_rdata [NI];
  bit    m_err [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_bus_controller #(
      .RD_CYCLES  (RD),
      .WR_CYCLES  (WR),
      .WAIT_TX    (1'b1),
      .RX_BLOCKING(g >= 2),
      .TIMEOUT    (g == 1 ? 8 : (g == 3 ? 4 : 1024))
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .load          (ld[g]),
      .store         (st[g]),
      .sel_status    (sl[g]),
      .wdata         (wd[g]),
      .rdata         (rdo[g]),
      .stall_req     (stall[g]),
      .bus_data_in   (bd[g]),
      .bus_data_out  (bdo[g]),
      .write_bus     (wb[g]),
      .uart_rdn      (rdn[g]),
      .uart_wrn      (wrn[g]),
      .uart_dataready(dr[g]),
      .uart_tbre     (tb[g]),
      .uart_tsre     (ts[g])
    );
  end

  typedef struct {
    int    stall;
    int    rdn;
    int    wrn;
    int    wb;
    int    rdn_first;
    int    rel;
    word_t rdata;
    bit    bdo_ok;
  } obs_t;

  function automatic int tmo_of(input int i);
    return (i == 1) ? 8 : ((i == 3) ? 4 : 1024);
  endfunction

  function automatic bit rxb_of(input int i);
    return i >= 2;
  endfunction

  function automatic word_t status_of(input bit e, input bit d,
                                      input bit b, input bit s);
    return (e ? 4 : 0) + (d ? 2 : 0) + ((b && s) ? 1 : 0);
  endfunction

  // Release cycle (first cycle with stall low) of a write, counted from
  // the request cycle; waits start WR+2 cycles in.
  function automatic int wr_release(input int to, input int tb_at,
                                    input int ts_at, output bit err);
    int t0, tbc, t1, tsc;
    err = 1'b0;
    t0  = WR + 2;
    tbc = (tb_at > t0) ? tb_at : t0;
    if (to != 0 && tbc - t0 >= to) begin
      err = 1'b1;
      return t0 + to - 1;
    end
    t1  = tbc + 1;
    tsc = (ts_at > t1) ? ts_at : t1;
    if (to != 0 && tsc - t1 >= to) begin
      err = 1'b1;
      return t1 + to - 1;
    end
    return tsc;
  endfunction

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (op %0d): observed 0x%0h expected 0x%0h",
             tag, op_id, obs, exp);
    end
  endtask

  // Runs one request from a cycle start; request held while stalled.
  task automatic txn(input int i, input bit l, input bit s, input bit ss,
                     input word_t wv, input word_t bv, input int dr_at,
                     input int tb_at, input int ts_at, input int maxc,
                     output obs_t o);
    o.stall = 0;
    o.rdn = 0;
    o.wrn = 0;
    o.wb = 0;
    o.rdn_first = -1;
    o.rel = -1;
    o.rdata = '0;
    o.bdo_ok = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      ld[i] = (o.rel < 0) ? l : 1'b0;
      st[i] = (o.rel < 0) ? s : 1'b0;
      sl[i] = ss;
      wd[i] = wv;
      bd[i] = bv;
      dr[i] = (c >= dr_at);
      tb[i] = (c >= tb_at);
      ts[i] = (c >= ts_at);
      @(negedge clk);
      if (stall[i]) o.stall++;
      if (!rdn[i]) begin
        o.rdn++;
        if (o.rdn_first < 0) o.rdn_first = c;
      end
      if (!wrn[i]) o.wrn++;
      if (wb[i]) begin
        o.wb++;
        if (bdo[i] !== 32'(wv[7:0])) o.bdo_ok = 1'b0;
      end
      if (o.rel < 0 && !stall[i]) begin
        o.rel = c;
        o.rdata = rdo[i];
      end
      @(posedge clk);
      #1;
    end
    ld[i] = 1'b0;
    st[i] = 1'b0;
  endtask

  task automatic do_read(input int i, input word_t bv, input int dr_at);
    obs_t o;
    int first, rel, drc, to;
    bit t;
    op_id++;
    to = tmo_of(i);
    t = 1'b0;
    first = 1;
    if (rxb_of(i)) begin
      drc = (dr_at > 1) ? dr_at : 1;
      t = (to != 0) && (drc - 1 >= to);
      first = drc + 1;
    end
    if (t) begin
      rel = 1 + to;
      m_rdata[i] = '0;
      m_err[i] = 1'b1;
    end else begin
      rel = first + RD;
      m_rdata[i] = bv & 32'hFF;
    end
    txn(i, 1'b1, 1'b0, 1'b0, $urandom, bv, dr_at, NEVER, NEVER, rel + 3, o);
    check("rd_release", o.rel, rel);
    check("rd_stall", o.stall, rel);
    check("rd_rdn_cycles", o.rdn, t ? 0 : RD);
    check("rd_rdn_first", o.rdn_first, t ? -1 : first);
    check("rd_rdata", o.rdata, m_rdata[i]);
    check("rd_no_wrn", o.wrn + o.wb, 0);
  endtask

  task automatic do_write(input int i, input word_t wv, input bit also_ld,
                          input int tb_at, input int ts_at);
    obs_t o;
    int rel;
    bit e;
    op_id++;
    rel = wr_release(tmo_of(i), tb_at, ts_at, e);
    txn(i, also_ld, 1'b1, 1'b0, wv, $urandom, NEVER, tb_at, ts_at,
        rel + 3, o);
    if (e) m_err[i] = 1'b1;
    check("wr_release", o.rel, rel);
    check("wr_stall", o.stall, rel);
    check("wr_wrn_cycles", o.wrn, WR);
    check("wr_bus_cycles", o.wb, WR + 1);
    check("wr_bus_data", 32'(o.bdo_ok), 1);
    check("wr_no_rdn", o.rdn, 0);
    check("wr_rdata_kept", o.rdata, m_rdata[i]);
  endtask

  task automatic do_status(input int i, input bit d, input bit b,
                           input bit s);
    obs_t o;
    word_t e;
    op_id++;
    e = status_of(m_err[i], d, b, s);
    txn(i, 1'b1, 1'b0, 1'b1, $urandom, $urandom, d ? 0 : NEVER,
        b ? 0 : NEVER, s ? 0 : NEVER, 4, o);
    m_rdata[i] = e;
    m_err[i] = 1'b0;
    check("st_release", o.rel, 1);
    check("st_stall", o.stall, 1);
    check("st_rdata", o.rdata, e);
    check("st_no_strobe", o.rdn + o.wrn + o.wb, 0);
  endtask

  task automatic do_ignored(input int i);
    obs_t o;
    op_id++;
    txn(i, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 0, 0, 0, 4, o);
    check("ign_release", o.rel, 0);
    check("ign_activity", o.stall + o.rdn + o.wrn + o.wb, 0);
    check("ign_rdata", o.rdata, m_rdata[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      ld[i] = 1'b0;
      st[i] = 1'b0;
      sl[i] = 1'b0;
      dr[i] = 1'b0;
      tb[i] = 1'b0;
      ts[i] = 1'b0;
      wd[i] = $urandom;
      bd[i] = $urandom;
      m_rdata[i] = '0;
      m_err[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_rdata", rdo[i], 0);
      check("rst_stall", 32'(stall[i]), 0);
      check("rst_rdn", 32'(rdn[i]), 1);
      check("rst_wrn", 32'(wrn[i]), 1);
      check("rst_write_bus", 32'(wb[i]), 0);
      check("rst_bus_out", bdo[i], 32'(wd[i][7:0]));
    end
    @(posedge clk);
    #1;

    do_read(0, 32'hA5A5_A53C, NEVER);
    do_write(0, 32'h1234_5641, 1'b0, WR + 1 + 5, WR + 1 + 8);
    do_write(1, $urandom, 1'b0, NEVER, NEVER);
    do_status(1, 1'b1, 1'b1, 1'b1);
    do_status(1, 1'b1, 1'b1, 1'b1);
    do_write(0, $urandom, 1'b1, 0, 0);
    do_ignored(0);
    do_read(2, $urandom, 11);
    do_read(3, $urandom, 2);
    do_read(3, $urandom, 4);
    do_read(3, $urandom, NEVER);
    do_status(3, 1'b0, 1'b1, 1'b1);

    op_id++;
    st[0] = 1'b1;
    sl[0] = 1'b0;
    wd[0] = 32'h0000_00C7;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstmid_pulse1_wrn", 32'(wrn[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    st[0] = 1'b0;
    @(negedge clk);
    check("rstmid_pulse2_wrn", 32'(wrn[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_wrn", 32'(wrn[0]), 1);
    check("rstmid_write_bus", 32'(wb[0]), 0);
    check("rstmid_stall", 32'(stall[0]), 0);
    check("rstmid_rdata", rdo[0], 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      m_rdata[i] = '0;
      m_err[i] = 1'b0;
    end
    do_read(0, $urandom, NEVER);
    do_status(1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int i;
      i = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: do_read(i, $urandom, NEVER);
        1: do_write(i, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, WR + 12), $urandom_range(0, WR + 16));
        default: do_status(i, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
